// File: rtl/turfbus_pkg.sv
// Shared encodings and frame constants for the TURFbus serial link.
// Frame layouts change when TURFBUS_PARITY_EN is defined.
package turfbus_pkg;

  typedef enum logic [2:0] {
    RX_SYNC,
    RX_IDLE,
    RX_HDR,
    RX_DATA,
    RX_PAR,
    RX_STOP
  } rx_state_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_STAT,
    TX_DATA,
    TX_PAR,
    TX_STOP
  } tx_state_e;

  // Logical bit values; the wires carry the complement.
  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

`ifdef TURFBUS_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  function automatic int req_frame_len(input int addr_w, input int data_w, input logic we);
    return 3 + addr_w + PAR_BITS + (we ? data_w : 0);
  endfunction

  function automatic int rsp_frame_len(input int data_w, input logic rd_ok);
    return 3 + PAR_BITS + (rd_ok ? data_w : 0);
  endfunction

endpackage

// File: rtl/turfbus_link_tx.sv
// Response serializer: start, status, optional read data, [parity], stop on SREQ_neg.
// Parity bit before stop when TURFBUS_PARITY_EN is defined.
module turfbus_link_tx
  import turfbus_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  rsp_valid_i,
  output logic                  rsp_ready_o,
  input  logic                  rsp_we_i,
  input  logic                  rsp_err_i,
  input  logic [DATA_WIDTH-1:0] rsp_dat_i,
  output logic                  SREQ_neg
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  tx_state_e             state;
  logic                  err_q;
  logic                  rd_ok_q;
  logic [DATA_WIDTH-1:0] sh_q;
  logic [CNT_W-1:0]      cnt_q;
  tx_state_e             tail_state;
  logic                  tail_neg;

`ifdef TURFBUS_PARITY_EN
  logic par_q;
  assign tail_state = TX_PAR;
  assign tail_neg   = ~par_q;
`else
  assign tail_state = TX_STOP;
  assign tail_neg   = ~STOP_BIT;
`endif

  // SREQ_neg is registered: each transition loads the level of the bit being entered.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= TX_IDLE;
      rsp_ready_o <= 1'b0;
      SREQ_neg    <= ~STOP_BIT;
      err_q       <= 1'b0;
      rd_ok_q     <= 1'b0;
      sh_q        <= '0;
      cnt_q       <= '0;
`ifdef TURFBUS_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      case (state)
        TX_IDLE: begin
          if (rsp_valid_i && rsp_ready_o) begin
            rsp_ready_o <= 1'b0;
            err_q       <= rsp_err_i;
            rd_ok_q     <= !rsp_we_i && !rsp_err_i;
            sh_q        <= rsp_dat_i;
`ifdef TURFBUS_PARITY_EN
            par_q       <= rsp_err_i ^ ((!rsp_we_i && !rsp_err_i) ? ^rsp_dat_i : 1'b0);
`endif
            SREQ_neg    <= ~START_BIT;
            state       <= TX_START;
          end else begin
            rsp_ready_o <= 1'b1;
          end
        end
        TX_START: begin
          SREQ_neg <= ~err_q;
          state    <= TX_STAT;
        end
        TX_STAT: begin
          if (rd_ok_q) begin
            SREQ_neg <= ~sh_q[DATA_WIDTH-1];
            sh_q     <= sh_q << 1;
            cnt_q    <= CNT_W'(DATA_WIDTH - 1);
            state    <= TX_DATA;
          end else begin
            SREQ_neg <= tail_neg;
            state    <= tail_state;
          end
        end
        TX_DATA: begin
          if (cnt_q == '0) begin
            SREQ_neg <= tail_neg;
            state    <= tail_state;
          end else begin
            SREQ_neg <= ~sh_q[DATA_WIDTH-1];
            sh_q     <= sh_q << 1;
            cnt_q    <= cnt_q - CNT_W'(1);
          end
        end
        TX_PAR: begin
          SREQ_neg <= ~STOP_BIT;
          state    <= TX_STOP;
        end
        TX_STOP: begin
          rsp_ready_o <= 1'b1;
          state       <= TX_IDLE;
        end
        default: begin
          SREQ_neg <= ~STOP_BIT;
          state    <= TX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/turfbus_link.sv
// TURFbus link layer: deframes TREQ_neg into requests, serializes completions on SREQ_neg.
// Request/response parity is added when TURFBUS_PARITY_EN is defined.
module turfbus_link
  import turfbus_pkg::*;
#(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 32,
  parameter int IDLE_MIN   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  TREQ_neg,
  output logic                  SREQ_neg,
  output logic                  req_valid_o,
  input  logic                  req_ready_i,
  output logic                  req_we_o,
  output logic [ADDR_WIDTH-1:0] req_adr_o,
  output logic [DATA_WIDTH-1:0] req_dat_o,
  input  logic                  rsp_valid_i,
  output logic                  rsp_ready_o,
  input  logic                  rsp_we_i,
  input  logic                  rsp_err_i,
  input  logic [DATA_WIDTH-1:0] rsp_dat_i,
  output logic                  err_frame_o,
  output logic                  err_overrun_o
);

  localparam int CNT_MAX = (ADDR_WIDTH > DATA_WIDTH)
                         ? ((ADDR_WIDTH > IDLE_MIN) ? ADDR_WIDTH : IDLE_MIN)
                         : ((DATA_WIDTH > IDLE_MIN) ? DATA_WIDTH : IDLE_MIN);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic                  d_p0;
  rx_state_e             rx_state;
  logic [CNT_W-1:0]      rx_cnt;
  logic [ADDR_WIDTH:0]   hdr_q;
  logic [DATA_WIDTH-1:0] dat_q;
  logic                  par_fail;
  logic                  stop_ok;
  logic                  stop_bad;
  logic                  held;

`ifdef TURFBUS_PARITY_EN
  localparam rx_state_e RX_TAIL = RX_PAR;
  logic par_acc_q;
  logic par_bad_q;
  assign par_fail = par_bad_q;
`else
  localparam rx_state_e RX_TAIL = RX_STOP;
  assign par_fail = 1'b0;
`endif

  assign stop_ok  = (rx_state == RX_STOP) && (d_p0 == STOP_BIT) && !par_fail;
  assign stop_bad = (rx_state == RX_STOP) && !stop_ok;
  assign held     = req_valid_o && !req_ready_i;

  // Stage p0: registered logical line bit; every RX decision below uses it.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      d_p0     <= STOP_BIT;
      rx_state <= RX_SYNC;
      rx_cnt   <= '0;
      hdr_q    <= '0;
      dat_q    <= '0;
`ifdef TURFBUS_PARITY_EN
      par_acc_q <= 1'b0;
      par_bad_q <= 1'b0;
`endif
    end else begin
      d_p0 <= ~TREQ_neg;
      case (rx_state)
        RX_SYNC: begin
          if (d_p0) begin
            rx_cnt <= '0;
          end else if (rx_cnt == CNT_W'(IDLE_MIN - 1)) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        RX_IDLE: begin
          if (d_p0 == START_BIT) begin
            rx_cnt   <= CNT_W'(ADDR_WIDTH);
            dat_q    <= '0;
            rx_state <= RX_HDR;
`ifdef TURFBUS_PARITY_EN
            par_acc_q <= 1'b0;
            par_bad_q <= 1'b0;
`endif
          end
        end
        RX_HDR: begin
          hdr_q <= {hdr_q[ADDR_WIDTH-1:0], d_p0};
`ifdef TURFBUS_PARITY_EN
          par_acc_q <= par_acc_q ^ d_p0;
`endif
          // On the last header bit the write flag sits just below the top.
          if (rx_cnt == '0) begin
            if (hdr_q[ADDR_WIDTH-1]) begin
              rx_cnt   <= CNT_W'(DATA_WIDTH - 1);
              rx_state <= RX_DATA;
            end else begin
              rx_state <= RX_TAIL;
            end
          end else begin
            rx_cnt <= rx_cnt - CNT_W'(1);
          end
        end
        RX_DATA: begin
          dat_q <= {dat_q[DATA_WIDTH-2:0], d_p0};
`ifdef TURFBUS_PARITY_EN
          par_acc_q <= par_acc_q ^ d_p0;
`endif
          if (rx_cnt == '0) begin
            rx_state <= RX_TAIL;
          end else begin
            rx_cnt <= rx_cnt - CNT_W'(1);
          end
        end
        RX_PAR: begin
`ifdef TURFBUS_PARITY_EN
          par_bad_q <= par_acc_q ^ d_p0;
          rx_state  <= RX_STOP;
`else
          rx_state  <= RX_SYNC;
`endif
        end
        RX_STOP: begin
          rx_cnt   <= '0;
          rx_state <= stop_ok ? RX_IDLE : RX_SYNC;
        end
        default: begin
          rx_cnt   <= '0;
          rx_state <= RX_SYNC;
        end
      endcase
    end
  end

  // Stage p1: request delivery; a frame completing while the last one is stalled is dropped.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      req_valid_o   <= 1'b0;
      req_we_o      <= 1'b0;
      req_adr_o     <= '0;
      req_dat_o     <= '0;
      err_frame_o   <= 1'b0;
      err_overrun_o <= 1'b0;
    end else begin
      err_frame_o   <= stop_bad;
      err_overrun_o <= stop_ok && held;
      if (stop_ok && !held) begin
        req_valid_o <= 1'b1;
        req_we_o    <= hdr_q[ADDR_WIDTH];
        req_adr_o   <= hdr_q[ADDR_WIDTH-1:0];
        req_dat_o   <= dat_q;
      end else if (req_valid_o && req_ready_i) begin
        req_valid_o <= 1'b0;
      end
    end
  end

  turfbus_link_tx #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_tx (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .rsp_valid_i (rsp_valid_i),
    .rsp_ready_o (rsp_ready_o),
    .rsp_we_i    (rsp_we_i),
    .rsp_err_i   (rsp_err_i),
    .rsp_dat_i   (rsp_dat_i),
    .SREQ_neg    (SREQ_neg)
  );

endmodule

// File: tb/tb_turfbus_link.sv
// Randomized bench for turfbus_link: frames built from field values, scoreboard of expected requests.
module tb_turfbus_link;

  localparam int AW       = 20;
  localparam int DW       = 32;
  localparam int IDLE_MIN = 4;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
  } req_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          TREQ_neg = 1'b1;
  logic          req_ready = 1'b0;
  logic          rsp_valid = 1'b0;
  logic          rsp_we = 1'b0;
  logic          rsp_err = 1'b0;
  logic [DW-1:0] rsp_dat = '0;
  logic          SREQ_neg;
  logic          req_valid_o;
  logic          req_we_o;
  logic [AW-1:0] req_adr_o;
  logic [DW-1:0] req_dat_o;
  logic          rsp_ready_o;
  logic          err_frame_o;
  logic          err_overrun_o;

  int   n_chk = 0;
  int   n_fail = 0;
  int   n_ferr = 0;
  int   n_ovr = 0;
  req_t exp_q[$];
  bit   fr_q[$];

  always #5 clk = ~clk;

  turfbus_link #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .IDLE_MIN   (IDLE_MIN)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .TREQ_neg      (TREQ_neg),
    .SREQ_neg      (SREQ_neg),
    .req_valid_o   (req_valid_o),
    .req_ready_i   (req_ready),
    .req_we_o      (req_we_o),
    .req_adr_o     (req_adr_o),
    .req_dat_o     (req_dat_o),
    .rsp_valid_i   (rsp_valid),
    .rsp_ready_o   (rsp_ready_o),
    .rsp_we_i      (rsp_we),
    .rsp_err_i     (rsp_err),
    .rsp_dat_i     (rsp_dat),
    .err_frame_o   (err_frame_o),
    .err_overrun_o (err_overrun_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: any presented request must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n) begin
      if (err_frame_o) n_ferr++;
      if (err_overrun_o) n_ovr++;
      if (req_valid_o) begin
        if (exp_q.size() == 0) begin
          chk("req_unexpected", 64'(req_valid_o), 64'd0);
        end else begin
          chk("req_we", 64'(req_we_o), 64'(exp_q[0].we));
          chk("req_adr", 64'(req_adr_o), 64'(exp_q[0].adr));
          chk("req_dat", 64'(req_dat_o), 64'(exp_q[0].dat));
          if (req_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic build_req(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                           input logic stop_lvl);
    logic par;
    par = we ^ (^adr) ^ (we ? ^dat : 1'b0);
    fr_q.delete();
    fr_q.push_back(1'b1);
    fr_q.push_back(we);
    for (int i = AW - 1; i >= 0; i--) fr_q.push_back(adr[i]);
    if (we) for (int i = DW - 1; i >= 0; i--) fr_q.push_back(dat[i]);
`ifdef TURFBUS_PARITY_EN
    fr_q.push_back(par);
`else
    if (par === 1'bx) fr_q.push_back(1'b0);
`endif
    fr_q.push_back(stop_lvl);
  endtask

  task automatic send_frame();
    while (fr_q.size() > 0) begin
      @(posedge clk);
      #1 TREQ_neg = ~fr_q.pop_front();
    end
  endtask

  task automatic idle_bits(input int n);
    repeat (n) begin
      @(posedge clk);
      #1 TREQ_neg = 1'b1;
    end
  endtask

  task automatic send_req(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                          input bit dropped);
    req_t r;
    build_req(we, adr, dat, 1'b0);
    send_frame();
    r.we  = we;
    r.adr = adr;
    r.dat = we ? dat : '0;
    if (!dropped) exp_q.push_back(r);
  endtask

  task automatic tx_resp(input logic we, input logic err, input logic [DW-1:0] dat);
    bit          eb[$];
    bit          got;
    logic        rd_ok;
    logic        busy_at_stop;
    logic [63:0] obsv;
    logic [63:0] expv;
    @(posedge clk);
    #1;
    rsp_valid = 1'b1;
    rsp_we    = we;
    rsp_err   = err;
    rsp_dat   = dat;
    got = 1'b0;
    for (int t = 0; t < 100 && !got; t++) begin
      @(negedge clk);
      if (rsp_ready_o) got = 1'b1;
    end
    chk("tx_accept", 64'(got), 64'd1);
    if (!got) begin
      rsp_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 rsp_valid = 1'b0;
    rd_ok = !we && !err;
    eb.push_back(1'b0);
    eb.push_back(~err);
    if (rd_ok) for (int i = DW - 1; i >= 0; i--) eb.push_back(~dat[i]);
`ifdef TURFBUS_PARITY_EN
    eb.push_back(~(err ^ (rd_ok ? ^dat : 1'b0)));
`endif
    eb.push_back(1'b1);
    obsv = '0;
    expv = '0;
    busy_at_stop = 1'b1;
    for (int i = 0; i < eb.size(); i++) begin
      @(negedge clk);
      obsv = {obsv[62:0], SREQ_neg};
      expv = {expv[62:0], eb[i]};
      busy_at_stop = rsp_ready_o;
    end
    chk("tx_frame", obsv, expv);
    chk("tx_busy_at_stop", 64'(busy_at_stop), 64'd0);
    @(negedge clk);
    chk("tx_ready_after", 64'(rsp_ready_o), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ferr0, ovr0;
    logic [DW-1:0] rd;

    // Reset values
    #22;
    chk("rst_sreq", 64'(SREQ_neg), 64'd1);
    chk("rst_valid", 64'(req_valid_o), 64'd0);
    chk("rst_we", 64'(req_we_o), 64'd0);
    chk("rst_adr", 64'(req_adr_o), 64'd0);
    chk("rst_dat", 64'(req_dat_o), 64'd0);
    chk("rst_rsp_ready", 64'(rsp_ready_o), 64'd0);
    chk("rst_errs", {62'd0, err_frame_o, err_overrun_o}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_before_clk", 64'(rsp_ready_o), 64'd0);
    @(negedge clk);
    chk("rdy_first_clk", 64'(rsp_ready_o), 64'd1);

    // Directed read with delivery latency
    req_ready = 1'b1;
    idle_bits(IDLE_MIN + 2);
    send_req(1'b0, 20'h12345, '0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("rd_valid_early", 64'(req_valid_o), 64'd0);
    @(negedge clk);
    chk("rd_valid_lat", 64'(req_valid_o), 64'd1);
    idle_bits(2);

    // Directed write, then completions
    send_req(1'b1, 20'h00010, 32'hDEADBEEF, 1'b0);
    idle_bits(3);
    tx_resp(1'b1, 1'b0, 32'h0);
    tx_resp(1'b0, 1'b0, 32'hA5A5_0F0F);
    tx_resp(1'b0, 1'b1, 32'hFFFF_0000);

    // Random traffic, RX and TX concurrently, back-to-back frames allowed
    for (int k = 0; k < 10; k++) begin
      logic          rwe, twe, terr;
      logic [AW-1:0] radr;
      logic [DW-1:0] rdat, tdat;
      rwe  = 1'($urandom);
      radr = AW'($urandom);
      rdat = $urandom;
      twe  = 1'($urandom);
      terr = ($urandom_range(0, 3) == 0);
      tdat = $urandom;
      fork
        send_req(rwe, radr, rdat, 1'b0);
        tx_resp(twe, terr, tdat);
      join
      idle_bits($urandom_range(0, 2));
    end
    idle_bits(4);
    chk("rand_drain", 64'(exp_q.size()), 64'd0);

    // Overrun: second frame dropped while first is stalled
    ovr0 = n_ovr;
    req_ready = 1'b0;
    send_req(1'b1, 20'hABCDE, 32'h1357_9BDF, 1'b0);
    send_req(1'b0, 20'h00777, '0, 1'b1);
    idle_bits(4);
    chk("ovr_pulse", 64'(n_ovr - ovr0), 64'd1);
    chk("ovr_held", 64'(req_valid_o), 64'd1);
    // Handshake in the same cycle the next frame completes: no overrun
    send_req(1'b0, 20'h0F0F0, '0, 1'b0);
    @(posedge clk);
    #1 req_ready = 1'b1;
    idle_bits(4);
    chk("ovr_same_cycle", 64'(n_ovr - ovr0), 64'd1);
    chk("ovr_drain", 64'(exp_q.size()), 64'd0);

    // Bad stop bit, then a start bit ignored until resynchronised
    ferr0 = n_ferr;
    build_req(1'b0, 20'h2468A, '0, 1'b1);
    send_frame();
    build_req(1'b0, 20'hFFFFF, '0, 1'b0);
    send_frame();
    idle_bits(3);
    chk("ferr_pulse", 64'(n_ferr - ferr0), 64'd1);
    chk("ferr_no_req", 64'(req_valid_o), 64'd0);
    idle_bits(IDLE_MIN);
    send_req(1'b1, 20'h55AA5, 32'hCAFE_F00D, 1'b0);
    idle_bits(4);
    chk("ferr_recover", 64'(exp_q.size()), 64'd0);

    // Reset in the middle of a request frame and a response frame
    req_ready = 1'b0;
    send_req(1'b1, 20'h31415, 32'h2718_2818, 1'b0);
    idle_bits(2);
    chk("pre_rst_valid", 64'(req_valid_o), 64'd1);
    @(posedge clk);
    #1;
    rsp_valid = 1'b1;
    rsp_we    = 1'b0;
    rsp_err   = 1'b0;
    rsp_dat   = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 rsp_valid = 1'b0;
    build_req(1'b1, 20'h0ACE1, 32'h0BAD_CAFE, 1'b0);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1 TREQ_neg = ~fr_q.pop_front();
    end
    chk("pre_rst_sreq", 64'(SREQ_neg), 64'd0);
    rst_n = 1'b0;
    exp_q.delete();
    fr_q.delete();
    TREQ_neg = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(req_valid_o), 64'd0);
    chk("mid_rst_adr", 64'(req_adr_o), 64'd0);
    chk("mid_rst_dat", 64'(req_dat_o), 64'd0);
    chk("mid_rst_we", 64'(req_we_o), 64'd0);
    chk("mid_rst_sreq", 64'(SREQ_neg), 64'd1);
    chk("mid_rst_rdy", 64'(rsp_ready_o), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    req_ready = 1'b1;
    idle_bits(IDLE_MIN + 2);
    rd = $urandom;
    send_req(1'b1, 20'h9ABCD, rd, 1'b0);
    idle_bits(4);
    chk("post_rst_drain", 64'(exp_q.size()), 64'd0);
    tx_resp(1'b0, 1'b0, rd);

    chk("ferr_total", 64'(n_ferr), 64'd1);
    chk("ovr_total", 64'(n_ovr), 64'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/turfbus_link.md
Name: turfbus_link

Overview:
- Bit-serial link layer of the TURFbus-to-WISHBONE bridge.
- Deframes TREQ_neg into parallel read/write requests that feed the bridge's WISHBONE master.
- Serializes the bridge's completions (ack/err, read data) back onto SREQ_neg.
- One bit per clk_i cycle in each direction; clk_i is the TURFbus clock domain.

Parameters:
- ADDR_WIDTH, 20, request address bits (matches the bridge's WISHBONE address width).
- DATA_WIDTH, 32, data bits per frame.
- IDLE_MIN, 4, consecutive idle bits required before RX accepts a start bit (after reset or error).

Ports:
- clk_i  in  1  single clock (TURFbus bit clock).
- rst_n_i  in  1  asynchronous active-low reset.
- TREQ_neg  in  1  serial request line, active-low: logical bit = ~TREQ_neg, idle = logical 0.
- SREQ_neg  out  1  serial response line, same polarity.
- req_valid_o  out  1  request available.
- req_ready_i  in  1  bridge accepts request.
- req_we_o  out  1  1 = write, 0 = read.
- req_adr_o  out  ADDR_WIDTH  request address.
- req_dat_o  out  DATA_WIDTH  write data; 0 for reads.
- rsp_valid_i  in  1  completion available.
- rsp_ready_o  out  1  TX idle, can take a completion.
- rsp_we_i  in  1  completion belongs to a write.
- rsp_err_i  in  1  WISHBONE err/timeout.
- rsp_dat_i  in  DATA_WIDTH  read data.
- err_frame_o  out  1  one-cycle pulse: bad stop bit.
- err_overrun_o  out  1  one-cycle pulse: frame dropped because request still held.

Behaviour:
- Reset (async assert, sync release):
  - SREQ_neg=1; req_valid_o=0; req_we_o=0; req_adr_o=0; req_dat_o=0; rsp_ready_o=0; err pulses 0.
  - RX enters SYNC; TX enters IDLE.
  - rsp_ready_o rises on the first clock after release.
- Input sampling: TREQ_neg is registered once (d = ~TREQ_neg); all RX decisions use d, giving 1 cycle of input latency.
- Request frame, MSB first: start(1), we, addr[ADDR_WIDTH-1:0], data[DATA_WIDTH-1:0] only if we=1, [parity], stop(0).
- RX FSM:
  - SYNC: count consecutive d=0 up to IDLE_MIN; any d=1 clears the count; reaching IDLE_MIN -> IDLE.
  - IDLE: d=1 -> HDR.
  - HDR: shift we + addr, ADDR_WIDTH+1 bits. Then DATA if we=1, otherwise PAR (or STOP when parity is compiled out).
  - DATA: DATA_WIDTH bits -> PAR/STOP.
  - PAR: 1 bit -> STOP.
  - STOP:
    - d=1: err_frame_o pulse, frame discarded, -> SYNC.
    - d=0 with no errors: deliver frame, -> IDLE. The next start bit may arrive on the very next cycle.
- Delivery:
  - req_valid_o rises the cycle after stop is sampled.
  - Outputs are held stable until req_valid_o & req_ready_i.
- Overrun: if a completed frame is ready to deliver while req_valid_o=1 and req_ready_i=0:
  - the new frame is dropped and err_overrun_o pulses;
  - the held request is unchanged.
  - A handshake completing in the same cycle as delivery is not an overrun; the new frame loads.
- TX FSM:
  - IDLE (rsp_ready_o=1): on rsp_valid_i, latch we/err/dat and drop rsp_ready_o -> START.
  - START: SREQ_neg=0 -> STAT.
  - STAT: drives ~err, then -> DATA if read and !err, otherwise -> STOP.
  - DATA: DATA_WIDTH bits MSB first.
  - STOP: SREQ_neg=1 -> IDLE.
  - Frame lengths: read-ok 35 bits; write or error 3 bits.
- RX and TX are fully independent and may run simultaneously.

Optional Feature:
- Macro: TURFBUS_PARITY_EN.
- Defined:
  - Request frames carry an even-parity bit covering we, addr and data, between payload and stop.
  - On mismatch the frame is dropped, err_frame_o pulses, and RX -> SYNC.
  - Responses carry an even-parity bit over err and data before stop, so a read-ok response is 36 bits.
- Undefined: no PAR state in either direction; frames are as listed above.

Decomposition:
- Package turfbus_pkg: RX/TX state encodings, START/STOP bit constants, frame-length localparams.
- Sub-module turfbus_link_tx holds the response serializer FSM; RX stays in turfbus_link.

Test Plan:
- Read frame, addr 0x12345, req_ready_i=1 -> req_valid_o one cycle after stop, we=0, adr=0x12345, dat=0.
- Write 0xDEADBEEF to 0x00010 -> request delivered; completion rsp_we_i=1, rsp_err_i=0 -> SREQ_neg shows 3-bit frame (start, stat=0 logical, stop).
- Read completion rsp_dat_i=0xA5A5_0F0F -> 35-cycle serial frame (36 with parity) with correct MSB-first data.
- Two back-to-back frames with req_ready_i=0 -> first held, err_overrun_o pulses once, first still presented.
- Stop bit forced to 1 -> err_frame_o pulse, no req_valid_o; start bits ignored until 4 idle bits seen.
- Reset asserted mid-frame -> outputs at reset values immediately; the next full frame after IDLE_MIN idle bits is decoded correctly.
